jtframe_mcu_romslot: RTL and testbench

- Responder side of the MCU program-ROM fetch interface: serves rom_addr/rom_cs from the MCU wrapper and returns rom_data/rom_ok.
- Fetches 16-bit words from the shared SDRAM controller and holds them in a tagged word buffer.
- The MCU's clock-gating logic stalls the CPU on rom_ok=0; this block determines that stall length.

---
 rtl/jtframe_mcu_romslot_if.sv | 54 +++++
 rtl/jtframe_mcu_romslot.sv | 149 ++++++++++++++
 tb/tb_jtframe_mcu_romslot.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_mcu_romslot_if.sv
// jtframe_mcu_romslot_if
// ----------------------
// Bus bundle between the MCU program-ROM fetch port, the ROM slot and the
// shared SDRAM arbiter.
//
// Signals (direction seen from the slot, modport slave):
//   rom_cs      in   MCU ROM access valid
//   rom_addr    in   MCU ROM byte address [ROMW-1:0]
//   rom_data    out  selected byte
//   rom_ok      out  rom_data valid for the current rom_addr
//   sdram_req   out  fetch request to the SDRAM arbiter
//   sdram_addr  out  SDRAM word address [SDRAMW-1:0]
//   sdram_ack   in   arbiter accepted the request
//   data_dst    in   data on the SDRAM bus belongs to this slot
//   data_rdy    in   SDRAM data valid
//   sdram_din   in   SDRAM word, low byte = even byte address
//   st_dbg      out  fetch FSM state, for observation only
//
// Handshakes:
//   MCU side   : rom_cs/rom_addr is a level request; the CPU stays stalled
//                while rom_ok=0 and rom_ok=1 means rom_data belongs to the
//                rom_addr presented in that same cycle.
//   SDRAM side : sdram_req/sdram_addr stay asserted and stable until a cycle
//                with sdram_ack=1; the word then arrives later in any cycle
//                with data_dst=1 and data_rdy=1 (data_rdy alone is for
//                another slot).
// The master modport is the environment (MCU wrapper + arbiter) view.

interface jtframe_mcu_romslot_if #(
   parameter int ROMW   = 12,
   parameter int SDRAMW = 22
);
   logic              rom_cs;
   logic [ROMW-1:0]   rom_addr;
   logic [7:0]        rom_data;
   logic              rom_ok;
   logic              sdram_req;
   logic [SDRAMW-1:0] sdram_addr;
   logic              sdram_ack;
   logic              data_dst;
   logic              data_rdy;
   logic [15:0]       sdram_din;
   logic [1:0]        st_dbg;

   modport slave (
      input  rom_cs, rom_addr, sdram_ack, data_dst, data_rdy, sdram_din,
      output rom_data, rom_ok, sdram_req, sdram_addr, st_dbg
   );

   modport master (
      output rom_cs, rom_addr, sdram_ack, data_dst, data_rdy, sdram_din,
      input  rom_data, rom_ok, sdram_req, sdram_addr, st_dbg
   );
endinterface

// File: rtl/jtframe_mcu_romslot.sv
// jtframe_mcu_romslot
// -------------------
// Responder for MCU program-ROM fetches. Keeps the last fetched 16-bit SDRAM
// word(s) in a tagged buffer; a buffer hit answers rom_ok in the same cycle,
// a miss fetches the word from SDRAM and keeps rom_ok low (stalling the CPU)
// until the word is in the buffer.
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   jtframe_mcu_romslot_if.slave (MCU ROM port + SDRAM request port)
//
// Parameters:
//   ROMW    MCU ROM byte-address width
//   SDRAMW  SDRAM word-address width
//   OFFSET  SDRAM word base of the MCU ROM region (address wraps at SDRAMW)
//
// Build option:
//   JTFRAME_MCU_ROMSLOT_DUAL_EN  two buffer entries with one-bit LRU
//                                replacement instead of a single entry.

module jtframe_mcu_romslot #(
   parameter int                ROMW   = 12,
   parameter int                SDRAMW = 22,
   parameter logic [SDRAMW-1:0] OFFSET = '0
)(
   input  logic                 clk,
   input  logic                 rst,
   jtframe_mcu_romslot_if.slave bus
);
   localparam int TW = ROMW - 1;   // tag = word address inside the ROM

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t        st;
   logic [TW-1:0] cur_tag;
   logic [TW-1:0] pend_tag;
   logic          hit;
   logic          fill;

   assign cur_tag    = bus.rom_addr[ROMW-1:1];
   assign fill       = (st == ST_WAIT) && bus.data_dst && bus.data_rdy;
   assign bus.rom_ok = hit;
   assign bus.st_dbg = st;

`ifdef JTFRAME_MCU_ROMSLOT_DUAL_EN
   logic [1:0][15:0]   word;
   logic [1:0][TW-1:0] tag;
   logic [1:0]         valid;
   logic [1:0]         match;
   logic               lru;      // index of the least recently used entry
   logic               lru_eff;  // LRU after this cycle's hit is accounted
   logic               victim;

   assign match[0] = valid[0] && (tag[0] == cur_tag);
   assign match[1] = valid[1] && (tag[1] == cur_tag);
   assign hit      = bus.rom_cs && (|match);
   // Byte select ignores rom_cs so the data path never depends on it.
   assign bus.rom_data = match[1] ?
                         (bus.rom_addr[0] ? word[1][15:8] : word[1][7:0]) :
                         (bus.rom_addr[0] ? word[0][15:8] : word[0][7:0]);

   // A hit in the same cycle as a fill makes the hit entry most recent
   // first, so the fill never evicts the word the CPU is using right now.
   always_comb begin
      lru_eff = lru;
      if (hit && match[0]) lru_eff = 1'b1;
      if (hit && match[1]) lru_eff = 1'b0;
   end

   assign victim = !valid[0] ? 1'b0 :
                   !valid[1] ? 1'b1 : lru_eff;

   always_ff @(posedge clk) begin
      if (rst) begin
         word  <= '0;
         tag   <= '0;
         valid <= '0;
         lru   <= 1'b0;
      end else if (fill) begin
         word[victim]  <= bus.sdram_din;
         tag[victim]   <= pend_tag;
         valid[victim] <= 1'b1;
         lru           <= ~victim;
      end else if (hit) begin
         lru <= lru_eff;
      end
   end
`else
   logic [15:0]   word;
   logic [TW-1:0] tag;
   logic          valid;

   assign hit          = bus.rom_cs && valid && (tag == cur_tag);
   assign bus.rom_data = bus.rom_addr[0] ? word[15:8] : word[7:0];

   // valid is only ever set here, so an old-tag hit keeps being served
   // until the very cycle the new word replaces it.
   always_ff @(posedge clk) begin
      if (rst) begin
         word  <= '0;
         tag   <= '0;
         valid <= 1'b0;
      end else if (fill) begin
         word  <= bus.sdram_din;
         tag   <= pend_tag;
         valid <= 1'b1;
      end
   end
`endif

   // Fetch FSM. A fetch is never aborted: once requested it always fills
   // with pend_tag, whatever rom_cs/rom_addr do meanwhile. A new miss is
   // only looked at from IDLE, so a miss seen during the fill cycle waits
   // one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         st             <= ST_IDLE;
         pend_tag       <= '0;
         bus.sdram_req  <= 1'b0;
         bus.sdram_addr <= '0;
      end else begin
         case (st)
            ST_IDLE: begin
               if (bus.rom_cs && !hit) begin
                  pend_tag       <= cur_tag;
                  bus.sdram_addr <= OFFSET + SDRAMW'(cur_tag);
                  bus.sdram_req  <= 1'b1;
                  st             <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (bus.sdram_ack) begin
                  bus.sdram_req <= 1'b0;
                  st            <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (fill) st <= ST_IDLE;
            end
            default: st <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_jtframe_mcu_romslot.sv
// tb_jtframe_mcu_romslot
// ----------------------
// Bench for jtframe_mcu_romslot. Inputs change on the falling clock edge and
// outputs are sampled 1 ns later. A second instance with a high OFFSET
// exercises the SDRAM address wrap. Compile with JTFRAME_MCU_ROMSLOT_DUAL_EN
// to cover the two-entry build.

module tb_jtframe_mcu_romslot;
   localparam int                ROMW    = 12;
   localparam int                SDRAMW  = 22;
   localparam logic [SDRAMW-1:0] OFFSET  = 22'h001000;
   localparam logic [SDRAMW-1:0] OFFSET2 = 22'h3FFF80;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   jtframe_mcu_romslot_if #(.ROMW(ROMW), .SDRAMW(SDRAMW)) bus  ();
   jtframe_mcu_romslot_if #(.ROMW(ROMW), .SDRAMW(SDRAMW)) bus2 ();

   jtframe_mcu_romslot #(.ROMW(ROMW), .SDRAMW(SDRAMW), .OFFSET(OFFSET)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   jtframe_mcu_romslot #(.ROMW(ROMW), .SDRAMW(SDRAMW), .OFFSET(OFFSET2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      bus.rom_cs    = 1'b0;
      bus.rom_addr  = '0;
      bus.sdram_ack = 1'b0;
      bus.data_dst  = 1'b0;
      bus.data_rdy  = 1'b0;
      bus.sdram_din = '0;
      bus2.rom_cs    = 1'b0;
      bus2.rom_addr  = '0;
      bus2.sdram_ack = 1'b0;
      bus2.data_dst  = 1'b0;
      bus2.data_rdy  = 1'b0;
      bus2.sdram_din = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   // Full miss/fill sequence for one byte address; leaves rom_cs high.
   task automatic fetch(input logic [ROMW-1:0] a, input logic [15:0] w);
      @(negedge clk);
      bus.rom_cs = 1'b1; bus.rom_addr = a;
      @(negedge clk);
      bus.sdram_ack = 1'b1;
      @(negedge clk);
      bus.sdram_ack = 1'b0; bus.data_dst = 1'b1; bus.data_rdy = 1'b1; bus.sdram_din = w;
      @(negedge clk);
      bus.data_dst = 1'b0; bus.data_rdy = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      clear_inputs();
      rst = 1'b1;
      bus.rom_cs = 1'b1; bus.rom_addr = 12'h123;
      @(negedge clk);
      #1;
      n_tests++; if (bus.sdram_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", bus.sdram_req); end
      n_tests++; if (bus.rom_ok !== 1'b0) begin n_fail++; $display("FAIL rst_ok: got %b want 0", bus.rom_ok); end
      n_tests++; if (bus.sdram_addr !== 22'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", bus.sdram_addr); end
      @(negedge clk);
      rst = 1'b0;
      bus.rom_cs = 1'b0;
   endtask

   task automatic test_miss_fill();
      do_reset();
      bus.rom_cs = 1'b1; bus.rom_addr = 12'h123;
      #1;
      n_tests++; if (bus.rom_ok !== 1'b0) begin n_fail++; $display("FAIL miss_ok0: got %b want 0", bus.rom_ok); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 2) bus.sdram_ack = 1'b1;
         #1;
         n_tests++; if (bus.sdram_req !== 1'b1) begin n_fail++; $display("FAIL miss_req%0d: got %b want 1", i, bus.sdram_req); end
         n_tests++; if (bus.sdram_addr !== 22'h001091) begin n_fail++; $display("FAIL miss_addr%0d: got %h want 001091", i, bus.sdram_addr); end
         n_tests++; if (bus.rom_ok !== 1'b0) begin n_fail++; $display("FAIL miss_stall%0d: got %b want 0", i, bus.rom_ok); end
      end
      @(negedge clk);
      bus.sdram_ack = 1'b0;
      bus.data_dst = 1'b1; bus.data_rdy = 1'b1; bus.sdram_din = 16'hBEEF;
      #1;
      n_tests++; if (bus.sdram_req !== 1'b0) begin n_fail++; $display("FAIL miss_reqdrop: got %b want 0", bus.sdram_req); end
      n_tests++; if (bus.rom_ok !== 1'b0) begin n_fail++; $display("FAIL miss_okearly: got %b want 0", bus.rom_ok); end
      @(negedge clk);
      bus.data_dst = 1'b0; bus.data_rdy = 1'b0;
      #1;
      n_tests++; if (bus.rom_ok !== 1'b1) begin n_fail++; $display("FAIL fill_ok: got %b want 1", bus.rom_ok); end
      n_tests++; if (bus.rom_data !== 8'hBE) begin n_fail++; $display("FAIL fill_data: got %h want be", bus.rom_data); end
   endtask

   task automatic test_hit();
      @(negedge clk);
      bus.rom_addr = 12'h122;
      #1;
      n_tests++; if (bus.rom_ok !== 1'b1) begin n_fail++; $display("FAIL hit_ok: got %b want 1", bus.rom_ok); end
      n_tests++; if (bus.rom_data !== 8'hEF) begin n_fail++; $display("FAIL hit_data: got %h want ef", bus.rom_data); end
      @(negedge clk);
      #1;
      n_tests++; if (bus.sdram_req !== 1'b0) begin n_fail++; $display("FAIL hit_noreq: got %b want 0", bus.sdram_req); end
      bus.rom_cs = 1'b0;
      #1;
      n_tests++; if (bus.rom_ok !== 1'b0) begin n_fail++; $display("FAIL nocs_ok: got %b want 0", bus.rom_ok); end
      n_tests++; if (bus.rom_data !== 8'hEF) begin n_fail++; $display("FAIL nocs_data: got %h want ef", bus.rom_data); end
      @(negedge clk);
      bus.rom_cs = 1'b1;
   endtask

   task automatic test_addr_change();
      @(negedge clk);
      bus.rom_cs = 1'b1; bus.rom_addr = 12'h200;
      @(negedge clk);
      bus.sdram_ack = 1'b1;
      @(negedge clk);
      bus.sdram_ack = 1'b0; bus.rom_addr = 12'h300;
      #1;
      n_tests++; if (bus.rom_ok !== 1'b0) begin n_fail++; $display("FAIL chg_ok_wait: got %b want 0", bus.rom_ok); end
      @(negedge clk);
      bus.data_dst = 1'b1; bus.data_rdy = 1'b1; bus.sdram_din = 16'h1234;
      @(negedge clk);
      bus.data_dst = 1'b0; bus.data_rdy = 1'b0;
      #1;
      n_tests++; if (bus.rom_ok !== 1'b0) begin n_fail++; $display("FAIL chg_ok_new: got %b want 0", bus.rom_ok); end
      n_tests++; if (bus.sdram_req !== 1'b0) begin n_fail++; $display("FAIL chg_req_fill: got %b want 0", bus.sdram_req); end
      @(negedge clk);
      bus.rom_addr = 12'h200;
      #1;
      n_tests++; if (bus.sdram_req !== 1'b1) begin n_fail++; $display("FAIL chg_req2: got %b want 1", bus.sdram_req); end
      n_tests++; if (bus.sdram_addr !== 22'h001180) begin n_fail++; $display("FAIL chg_addr2: got %h want 001180", bus.sdram_addr); end
      n_tests++; if (bus.rom_ok !== 1'b1 || bus.rom_data !== 8'h34) begin n_fail++; $display("FAIL chg_old_hit: got %b/%h want 1/34", bus.rom_ok, bus.rom_data); end
      @(negedge clk);
      bus.sdram_ack = 1'b1;
      @(negedge clk);
      bus.sdram_ack = 1'b0; bus.data_dst = 1'b1; bus.data_rdy = 1'b1; bus.sdram_din = 16'h5678;
      @(negedge clk);
      bus.data_dst = 1'b0; bus.data_rdy = 1'b0; bus.rom_addr = 12'h301;
      #1;
      n_tests++; if (bus.rom_ok !== 1'b1 || bus.rom_data !== 8'h56) begin n_fail++; $display("FAIL chg_fill2: got %b/%h want 1/56", bus.rom_ok, bus.rom_data); end
   endtask

   task automatic test_dst_filter();
      @(negedge clk);
      bus.rom_cs = 1'b1; bus.rom_addr = 12'h400;
      @(negedge clk);
      bus.sdram_ack = 1'b1;
      @(negedge clk);
      bus.sdram_ack = 1'b0; bus.data_rdy = 1'b1; bus.data_dst = 1'b0; bus.sdram_din = 16'hDEAD;
      @(negedge clk);
      bus.data_rdy = 1'b0;
      #1;
      n_tests++; if (bus.rom_ok !== 1'b0) begin n_fail++; $display("FAIL dst_nofill: got %b want 0", bus.rom_ok); end
      n_tests++; if (bus.sdram_req !== 1'b0) begin n_fail++; $display("FAIL dst_noreq: got %b want 0", bus.sdram_req); end
      @(negedge clk);
      #1;
      n_tests++; if (bus.rom_ok !== 1'b0) begin n_fail++; $display("FAIL dst_stillwait: got %b want 0", bus.rom_ok); end
      bus.data_dst = 1'b1; bus.data_rdy = 1'b1; bus.sdram_din = 16'hCAFE;
      @(negedge clk);
      bus.data_dst = 1'b0; bus.data_rdy = 1'b0;
      #1;
      n_tests++; if (bus.rom_ok !== 1'b1 || bus.rom_data !== 8'hFE) begin n_fail++; $display("FAIL dst_fill: got %b/%h want 1/fe", bus.rom_ok, bus.rom_data); end
   endtask

   task automatic test_reset_midfetch();
      @(negedge clk);
      bus.rom_cs = 1'b1; bus.rom_addr = 12'h500;
      @(negedge clk);
      #1;
      n_tests++; if (bus.sdram_req !== 1'b1) begin n_fail++; $display("FAIL rmf_req: got %b want 1", bus.sdram_req); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.data_dst = 1'b1; bus.data_rdy = 1'b1; bus.sdram_din = 16'h9999;
      #1;
      n_tests++; if (bus.sdram_req !== 1'b0) begin n_fail++; $display("FAIL rmf_reqclr: got %b want 0", bus.sdram_req); end
      n_tests++; if (bus.rom_ok !== 1'b0) begin n_fail++; $display("FAIL rmf_ok: got %b want 0", bus.rom_ok); end
      @(negedge clk);
      bus.data_dst = 1'b0; bus.data_rdy = 1'b0;
      #1;
      n_tests++; if (bus.rom_ok !== 1'b0) begin n_fail++; $display("FAIL rmf_late: got %b want 0", bus.rom_ok); end
      n_tests++; if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h001280) begin n_fail++; $display("FAIL rmf_rereq: got %b/%h want 1/001280", bus.sdram_req, bus.sdram_addr); end
      @(negedge clk);
      bus.sdram_ack = 1'b1;
      @(negedge clk);
      bus.sdram_ack = 1'b0; bus.data_dst = 1'b1; bus.data_rdy = 1'b1; bus.sdram_din = 16'h4321;
      @(negedge clk);
      bus.data_dst = 1'b0; bus.data_rdy = 1'b0;
      #1;
      n_tests++; if (bus.rom_ok !== 1'b1 || bus.rom_data !== 8'h21) begin n_fail++; $display("FAIL rmf_fill: got %b/%h want 1/21", bus.rom_ok, bus.rom_data); end
   endtask

   task automatic test_wrap();
      do_reset();
      bus2.rom_cs = 1'b1; bus2.rom_addr = 12'h300;
      @(negedge clk);
      #1;
      n_tests++; if (bus2.sdram_req !== 1'b1 || bus2.sdram_addr !== 22'h000100) begin n_fail++; $display("FAIL wrap_addr: got %b/%h want 1/000100", bus2.sdram_req, bus2.sdram_addr); end
      bus2.rom_cs = 1'b0;
   endtask

`ifdef JTFRAME_MCU_ROMSLOT_DUAL_EN
   task automatic test_dual_lru();
      do_reset();
      fetch(12'h010, 16'hA010);
      fetch(12'h020, 16'hA020);
      @(negedge clk);
      bus.rom_addr = 12'h010;
      #1;
      n_tests++; if (bus.rom_ok !== 1'b1 || bus.rom_data !== 8'h10) begin n_fail++; $display("FAIL dual_hit010: got %b/%h want 1/10", bus.rom_ok, bus.rom_data); end
      @(negedge clk);
      #1;
      n_tests++; if (bus.sdram_req !== 1'b0) begin n_fail++; $display("FAIL dual_noreq: got %b want 0", bus.sdram_req); end
      fetch(12'h030, 16'hA030);
      #1;
      n_tests++; if (bus.rom_ok !== 1'b1 || bus.rom_data !== 8'h30) begin n_fail++; $display("FAIL dual_hit030: got %b/%h want 1/30", bus.rom_ok, bus.rom_data); end
      bus.rom_addr = 12'h011;
      #1;
      n_tests++; if (bus.rom_ok !== 1'b1 || bus.rom_data !== 8'hA0) begin n_fail++; $display("FAIL dual_keep010: got %b/%h want 1/a0", bus.rom_ok, bus.rom_data); end
      @(negedge clk);
      #1;
      n_tests++; if (bus.sdram_req !== 1'b0) begin n_fail++; $display("FAIL dual_noreq2: got %b want 0", bus.sdram_req); end
      bus.rom_addr = 12'h020;
      #1;
      n_tests++; if (bus.rom_ok !== 1'b0) begin n_fail++; $display("FAIL dual_evict020: got %b want 0", bus.rom_ok); end
      @(negedge clk);
      bus.rom_cs = 1'b0;
   endtask
`endif

   // Random traffic against a cache-level model: a list of cached words in
   // recency order plus the one outstanding fetch (none / waiting for ack /
   // waiting for data).
   task automatic test_random();
      logic [ROMW-2:0]   mtag[$];
      logic [15:0]       mword[$];
      logic [ROMW-2:0]   pend;
      logic [ROMW-2:0]   t;
      logic [ROMW-2:0]   ttmp;
      logic [15:0]       wtmp;
      logic [SDRAMW-1:0] ea;
      logic              exp_ok;
      logic [7:0]        exp_d;
      int                phase;
      int                idx;
      int                cap;
`ifdef JTFRAME_MCU_ROMSLOT_DUAL_EN
      cap = 2;
`else
      cap = 1;
`endif
      do_reset();
      phase = 0;
      pend  = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         bus.rom_cs = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 3) == 0) begin
            t = ROMW'(0) + 11'($urandom_range(0, 5) * 11'h155);
            bus.rom_addr = {t, 1'($urandom_range(0, 1))};
         end
         bus.sdram_ack = ($urandom_range(0, 1) == 1);
         bus.data_rdy  = ($urandom_range(0, 4) < 2);
         bus.data_dst  = ($urandom_range(0, 9) < 7);
         bus.sdram_din = 16'($urandom);
         #1;
         t   = bus.rom_addr[ROMW-1:1];
         idx = -1;
         foreach (mtag[i]) if (mtag[i] == t) idx = i;
         exp_ok = bus.rom_cs && (idx >= 0);
         n_tests++; if (bus.rom_ok !== exp_ok) begin n_fail++; $display("FAIL rnd_ok c%0d: got %b want %b", c, bus.rom_ok, exp_ok); end
         if (idx >= 0) begin
            exp_d = bus.rom_addr[0] ? mword[idx][15:8] : mword[idx][7:0];
            n_tests++; if (bus.rom_data !== exp_d) begin n_fail++; $display("FAIL rnd_data c%0d: got %h want %h", c, bus.rom_data, exp_d); end
         end
         n_tests++; if (bus.sdram_req !== (phase == 1)) begin n_fail++; $display("FAIL rnd_req c%0d: got %b want %b", c, bus.sdram_req, (phase == 1)); end
         if (phase != 0) begin
            ea = OFFSET + SDRAMW'(pend);
            n_tests++; if (bus.sdram_addr !== ea) begin n_fail++; $display("FAIL rnd_addr c%0d: got %h want %h", c, bus.sdram_addr, ea); end
         end
         // model update for the coming rising edge
         if (exp_ok) begin
            ttmp = mtag[idx]; wtmp = mword[idx];
            mtag.delete(idx); mword.delete(idx);
            mtag.push_back(ttmp); mword.push_back(wtmp);
         end
         case (phase)
            0: if (bus.rom_cs && !exp_ok) begin pend = t; phase = 1; end
            1: if (bus.sdram_ack) phase = 2;
            default: if (bus.data_dst && bus.data_rdy) begin
               if (mtag.size() >= cap) begin
                  void'(mtag.pop_front()); void'(mword.pop_front());
               end
               mtag.push_back(pend); mword.push_back(bus.sdram_din);
               phase = 0;
            end
         endcase
      end
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_miss_fill();
      test_hit();
      test_addr_change();
      test_dst_filter();
      test_reset_midfetch();
      test_wrap();
`ifdef JTFRAME_MCU_ROMSLOT_DUAL_EN
      test_dual_lru();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
